// File: rtl/register_file_if.sv
// Bus between the datapath and the register file: two read ports and one write port.
// The master drives addresses and write data. The slave returns the read data.
interface register_file_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] read1;
    logic [ADDR_WIDTH-1:0] read2;
    logic [ADDR_WIDTH-1:0] writeTo;
    logic [DATA_WIDTH-1:0] writeDat;
    logic                  writeenable;
    logic [DATA_WIDTH-1:0] out1;
    logic [DATA_WIDTH-1:0] out2;

    modport master (
        output read1, read2, writeTo, writeDat, writeenable,
        input  out1, out2
    );

    modport slave (
        input  read1, read2, writeTo, writeDat, writeenable,
        output out1, out2
    );
endinterface

// File: rtl/register_file.sv
// 32 x 64-bit general-purpose register file with two combinational read ports and one write port.
// Every entry is ordinary storage, including index 0. Reset clears all entries synchronously.
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    register_file_if.slave         bus
);
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (bus.writeenable) begin
            regs_d[bus.writeTo] = bus.writeDat;
        end
    end

    // Reset wins over a same-cycle write, so write inputs may be X while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads have no write bypass. A same-index write appears only after the edge.
    assign bus.out1 = regs_q[bus.read1];
    assign bus.out2 = regs_q[bus.read2];
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. It uses directed table vectors, hand sequences,
// and random traffic checked against an array model of the register contents.
module tb_register_file;
    logic clk;
    logic rst;

    register_file_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wto;
        logic [63:0] wdat;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    vec_t        table_v [10];
    logic [63:0] model [32];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string name, input logic [63:0] e1, input logic [63:0] e2);
        vectors++;
        if (bus.out1 !== e1 || bus.out2 !== e2) begin
            miscompares++;
            $display("[TB] FAIL %s: out1=%h out2=%h, expected out1=%h out2=%h",
                     name, bus.out1, bus.out2, e1, e2);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and optionally check the
    // outputs before the rising edge. Then update the model at the rising edge.
    task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wto,
                                 input logic [63:0] wdat, input logic [4:0] r1,
                                 input logic [4:0] r2, input bit check_pre,
                                 input string name);
        @(negedge clk);
        rst             = r;
        bus.writeenable = we;
        bus.writeTo     = wto;
        bus.writeDat    = wdat;
        bus.read1       = r1;
        bus.read2       = r2;
        #1;
        if (check_pre) checkOutput({name, "_pre"}, model[r1], model[r2]);
        @(posedge clk);
        if (r) begin
            foreach (model[i]) model[i] = 64'd0;
        end else if (we) begin
            model[wto] = wdat;
        end
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        bus.writeenable = 1'b0;
        bus.writeTo     = '0;
        bus.writeDat    = '0;
        bus.read1       = '0;
        bus.read2       = '0;
        foreach (model[i]) model[i] = 64'd0;

        table_v[0] = '{1'b1, 1'b1, 5'd3,  64'hFFFF,             5'd0, 5'd31, 64'd0, 64'd0};
        table_v[1] = '{1'b0, 1'b1, 5'd0,  64'h1FFFFFFFFFFFFFF8, 5'd0, 5'd31, 64'h1FFFFFFFFFFFFFF8, 64'd0};
        table_v[2] = '{1'b0, 1'b1, 5'd31, 64'hF00000000000000F, 5'd0, 5'd31, 64'h1FFFFFFFFFFFFFF8, 64'hF00000000000000F};
        table_v[3] = '{1'b0, 1'b0, 5'd0,  64'h0,                5'd0, 5'd31, 64'h1FFFFFFFFFFFFFF8, 64'hF00000000000000F};
        table_v[4] = '{1'b1, 1'b0, 5'd0,  64'h0,                5'd0, 5'd31, 64'd0, 64'd0};
        table_v[5] = '{1'b0, 1'b1, 5'd5,  64'hDEADBEEF00000001, 5'd5, 5'd0,  64'hDEADBEEF00000001, 64'd0};
        table_v[6] = '{1'b0, 1'b0, 5'd5,  64'h1234,             5'd5, 5'd5,  64'hDEADBEEF00000001, 64'hDEADBEEF00000001};
        table_v[7] = '{1'b0, 1'b0, 5'd5,  64'h1234,             5'd5, 5'd5,  64'hDEADBEEF00000001, 64'hDEADBEEF00000001};
        table_v[8] = '{1'b0, 1'b0, 5'd5,  64'h1234,             5'd5, 5'd5,  64'hDEADBEEF00000001, 64'hDEADBEEF00000001};
        table_v[9] = '{1'b1, 1'b1, 5'd3,  64'hFFFF,             5'd3, 5'd5,  64'd0, 64'd0};

        // Contents are undefined before the first reset, so skip the pre-edge check for vector 0.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i].rst, table_v[i].we, table_v[i].wto, table_v[i].wdat,
                          table_v[i].r1, table_v[i].r2, (i != 0), $sformatf("table%0d", i));
            checkOutput($sformatf("table%0d", i), table_v[i].exp1, table_v[i].exp2);
        end

        // Every index reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            bus.read1 = 5'(i);
            bus.read2 = 5'(31 - i);
            #1;
            checkOutput($sformatf("reset_clear%0d", i), 64'd0, 64'd0);
        end

        // Read-during-write on both ports of the same index.
        applyStimulus(1'b0, 1'b1, 5'd7, 64'h5555, 5'd7, 5'd8, 1'b1, "rdw_setup7");
        applyStimulus(1'b0, 1'b1, 5'd8, 64'h1111, 5'd7, 5'd8, 1'b1, "rdw_setup8");
        @(negedge clk);
        bus.read1       = 5'd7;
        bus.read2       = 5'd7;
        bus.writeTo     = 5'd7;
        bus.writeDat    = 64'hAAAA;
        bus.writeenable = 1'b1;
        #1;
        checkOutput("rdw_before_edge", 64'h5555, 64'h5555);
        @(posedge clk);
        model[7] = 64'hAAAA;
        #1;
        checkOutput("rdw_after_edge", 64'hAAAA, 64'hAAAA);
        bus.writeenable = 1'b0;
        bus.read1       = 5'd8;
        bus.read2       = 5'd5;
        #1;
        checkOutput("rdw_others", 64'h1111, 64'd0);

        // Random traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            logic        r;
            logic        we;
            logic [63:0] d;
            r  = ($urandom_range(0, 24) == 0);
            we = ($urandom_range(0, 3) != 0);
            d  = {$urandom, $urandom};
            applyStimulus(r, we, 5'($urandom_range(0, 31)), d,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          1'b1, $sformatf("rand%0d", n));
            checkOutput($sformatf("rand%0d_post", n), model[bus.read1], model[bus.read2]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry × 64-bit general-purpose register file for the single-cycle 64-bit datapath.
- Two combinational read ports feed the ALU operand paths.
- One synchronous write port takes the writeback result.
- All 32 entries are ordinary storage. No entry is hardwired to zero.

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, number of entries (2**ADDR_WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; clears every register.
- read1  input  5  index of register driven on out1.
- read2  input  5  index of register driven on out2.
- writeTo  input  5  index of register to write.
- writeDat  input  64  data to write.
- writeenable  input  1  write strobe, active high.
- out1  output  64  contents of register[read1].
- out2  output  64  contents of register[read2].

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Storage: 32 registers of 64 bits, indices 0..31. Index 0 and index 31 are writable and readable like any other entry.
- Reset:
  - On a rising clk edge with rst=1, all 32 registers become 0.
  - Reset has priority over any write in the same cycle. writeenable, writeTo and writeDat are ignored during reset, even if X.
  - Outputs read 0 after the first reset edge (read ports are combinational).
  - Register contents before the first reset edge are undefined.
  - Reset asserted mid-operation clears all stored data at the next edge. Outputs follow combinationally.
- Write:
  - On a rising clk edge with rst=0 and writeenable=1, register[writeTo] takes writeDat.
  - One write per cycle.
  - writeenable=0 leaves all registers unchanged.
- Read:
  - out1 = register[read1] and out2 = register[read2], purely combinational (zero latency).
  - Outputs update within the same cycle as an address change or a stored-value change.
  - read1 and read2 may select the same register; both outputs then carry the same value.
- Read-during-write (same index, same cycle): outputs show the old value until the write edge and the new value immediately after. There is no write-to-read bypass before the edge.
- Unknown read addresses may produce X outputs. No other side effects.
- No handshake and no state machine.

Test Plan:
- Reset clear: hold rst=1 for one edge with arbitrary read1/read2 → out1=out2=0 for every index 0..31.
- Write index 0:
  - Stimulus: rst=0, writeenable=1, writeTo=0, writeDat=0x1FFFFFFFFFFFFFF8, one edge; then writeTo=31, writeDat=0xF00000000000000F, one edge.
  - Check: writeenable=0, read1=0, read2=31 → out1=0x1FFFFFFFFFFFFFF8, out2=0xF00000000000000F.
- Reset after data: with the above contents, rst=1 for one edge → out1=0, out2=0.
- Write-enable gating: write 0xDEADBEEF00000001 to index 5, then present writeDat=0x1234 with writeenable=0 for several edges → register 5 still reads 0xDEADBEEF00000001.
- Read-during-write and dual-port:
  - Stimulus: read1=read2=7 while writing 0xAAAA to index 7.
  - Before the edge: both outputs show the prior value.
  - After the edge: both outputs show 0xAAAA.
  - Other registers are unchanged.
- Reset priority: rst=1 and writeenable=1 with writeTo=3, writeDat=0xFFFF in the same cycle → register 3 reads 0 after the edge.
